// File: rtl/fsm_cond_pkg.sv
// Shared types and default timing constants for the input conditioner.
// Optional glitch counter is enabled with COND_GLITCH_CNT_EN.
package fsm_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SETTLE  = 2'b01,
    PUBLISH = 2'b10
  } cond_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_SKEW_CYCLES     = 2;
  localparam int DEF_CNT_W           = 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cond_debounce_ch.sv
// One channel: 2-flop synchroniser followed by a consecutive-cycle debounce counter.
// With COND_GLITCH_CNT_EN a strobe flags each rejected (too short) pulse.
module cond_debounce_ch
  import fsm_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb
`ifdef COND_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);

  localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (s2_q != deb_q) begin
      if (deb_cnt_q == DEB_TC) begin
        deb_d     = s2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + ONE;
      end
    end
  end

  assign deb = deb_q;

`ifdef COND_GLITCH_CNT_EN
  // A run that ended before acceptance: counter was running and the level fell back.
  assign glitch = (deb_cnt_q != '0) && (s2_q == deb_q);
`endif

endmodule

// File: rtl/fsm_input_conditioner.sv
// Synchronises, debounces and pair-aligns raw1/raw2 into coherent i1/i2 symbol pairs.
// Define COND_GLITCH_CNT_EN to add the saturating glitch_cnt output.
module fsm_input_conditioner
  import fsm_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SKEW_CYCLES     = DEF_SKEW_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw1,
  input  logic       raw2,
  output logic       i1,
  output logic       i2,
  output logic       sym_valid
`ifdef COND_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam logic [CNT_W-1:0] SKEW_TC = CNT_W'(SKEW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic        deb1, deb2;
  logic [1:0]  deb_pair;

  cond_state_t      state_q, state_d;
  logic [CNT_W-1:0] skew_cnt_q, skew_cnt_d;
  logic [1:0]       pair_q, pair_d;
  logic             sym_valid_q, sym_valid_d;

`ifdef COND_GLITCH_CNT_EN
  logic       glitch1, glitch2;
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
`endif

  cond_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw1),
    .deb   (deb1)
`ifdef COND_GLITCH_CNT_EN
    ,
    .glitch(glitch1)
`endif
  );

  cond_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw2),
    .deb   (deb2)
`ifdef COND_GLITCH_CNT_EN
    ,
    .glitch(glitch2)
`endif
  );

  assign deb_pair = {deb1, deb2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      skew_cnt_q  <= '0;
      pair_q      <= 2'b00;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      skew_cnt_q  <= skew_cnt_d;
      pair_q      <= pair_d;
      sym_valid_q <= sym_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (deb_pair != pair_q) begin
          state_d    = SETTLE;
          skew_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (deb_pair == pair_q) begin
          state_d    = IDLE;
          skew_cnt_d = '0;
        end else if (skew_cnt_q == SKEW_TC) begin
          state_d = PUBLISH;
        end else begin
          skew_cnt_d = skew_cnt_q + ONE;
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pair that drifted back to the current output is not re-announced.
  always_comb begin
    pair_d      = pair_q;
    sym_valid_d = 1'b0;
    if (state_q == PUBLISH) begin
      pair_d      = deb_pair;
      sym_valid_d = (deb_pair != pair_q);
    end
  end

  assign i1        = pair_q[1];
  assign i2        = pair_q[0];
  assign sym_valid = sym_valid_q;

`ifdef COND_GLITCH_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_cnt_q <= 8'h00;
    else     glitch_cnt_q <= glitch_cnt_d;
  end

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch1 || glitch2) glitch_cnt_d = sat_inc8(glitch_cnt_q);
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

endmodule
